// File: rtl/synth_multivoice.sv
// Multi-voice synthesizer front end.
// Holds up to 16 CPU-programmable voice words. Once per sample period it sweeps
// every voice through a shared voice engine, sums the returned samples, then
// scales and saturates the sum into one PCM word for the DAC.
//
// Handshakes:
//   CPU side    - wen/ren are held until ready. ready rises one cycle after the
//                 request and stays high while the request is held. A write
//                 commits on every clk edge where wen & ready.
//   Engine side - v_req is held with stable v_* until v_ack. v_sample is taken
//                 in the v_ack cycle. The next voice can be requested
//                 back-to-back.
module synth_multivoice #(
  parameter int NVOICES         = 16,
  parameter int BITDEPTH        = 14,
  parameter int SAMPLECLOCK_DIV = 8,
  parameter int MIXSHIFT        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 addr,
  input  logic [31:0]                data_in,
  output logic [31:0]                data_out,
  input  logic                       wen,
  input  logic                       ren,
  output logic                       ready,
  output logic                       v_req,
  output logic [3:0]                 v_idx,
  output logic                       v_cfg,
  output logic [6:0]                 v_tune,
  output logic [7:0]                 v_attack,
  output logic [7:0]                 v_decay,
  output logic [6:0]                 v_note,
  output logic                       v_gate,
  input  logic                       v_ack,
  input  logic signed [BITDEPTH-1:0] v_sample,
  output logic signed [BITDEPTH-1:0] pcm,
  output logic                       pcm_valid,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int AW = BITDEPTH + 4;
  localparam logic [3:0] LAST_IDX = 4'(NVOICES - 1);
  localparam logic signed [AW-1:0] PCM_MAX = {{5{1'b0}}, {(BITDEPTH-1){1'b1}}};
  localparam logic signed [AW-1:0] PCM_MIN = {{5{1'b1}}, {(BITDEPTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]                 voice_mem [16];
  logic                        ready_q;
  logic                        voice_ok;
  logic                        wr_voice;
  logic                        wr_status;
  logic [31:0]                 wr_word;
  logic [31:0]                 rdata;
  logic                        overrun;
  logic [SAMPLECLOCK_DIV-1:0]  sample_cnt;
  logic                        tick;
  logic [3:0]                  idx;
  logic signed [AW-1:0]        acc;
  logic signed [AW-1:0]        sample_ext;
  logic signed [AW-1:0]        shifted;
  logic signed [BITDEPTH-1:0]  pcm_next;
  logic                        start_sweep;
  logic                        take_sample;
  logic [3:0]                  snap_sel;
  logic [31:0]                 snap_word;

  // ---------------- CPU access ----------------
  assign ready     = ready_q & (wen | ren);
  assign voice_ok  = ~addr[4] && ({1'b0, addr[3:0]} < 5'(NVOICES));
  assign wr_voice  = wen & ready & voice_ok;
  assign wr_status = wen & ready & addr[4];

  // A word with cfg clear only updates note/gate and clears cfg; the
  // tune/attack/decay settings of the voice stay as they were.
  assign wr_word = data_in[31] ? data_in
                               : {1'b0, voice_mem[addr[3:0]][30:8], data_in[7:0]};

  // Acknowledge register: remembers that a request was already present last cycle.
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= wen | ren;
  end

  // Voice register file; slots at or above NVOICES stay zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) voice_mem[i] <= '0;
    end else if (wr_voice) begin
      voice_mem[addr[3:0]] <= wr_word;
    end
  end

  // Read mux: status register, in-range voice word, or zero.
  always_comb begin
    rdata = '0;
    if (addr[4])       rdata = {30'd0, busy, overrun};
    else if (voice_ok) rdata = voice_mem[addr[3:0]];
  end

  assign data_out = (ready & ren) ? rdata : '0;

  // ---------------- sample timing ----------------
  // Free-running sample-period divider; tick marks the last cycle of a period.
  always_ff @(posedge clk) begin
    if (rst) sample_cnt <= '0;
    else     sample_cnt <= sample_cnt + 1'b1;
  end

  assign tick = &sample_cnt;

  // Sticky overrun: a tick arriving mid-sweep is lost. Setting beats a CPU clear.
  always_ff @(posedge clk) begin
    if (rst)                                overrun <= 1'b0;
    else if (tick && (state != S_IDLE))     overrun <= 1'b1;
    else if (wr_status && data_in[0])       overrun <= 1'b0;
  end

  // ---------------- sweep scheduler ----------------
  // State register of the sweep scheduler.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and per-cycle sweep controls.
  always_comb begin
    state_next  = state;
    start_sweep = 1'b0;
    take_sample = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_next  = S_REQ;
          start_sweep = 1'b1;
        end
      end
      S_REQ: begin
        if (v_ack) begin
          take_sample = 1'b1;
          if (idx == LAST_IDX) state_next = S_OUT;
        end
      end
      S_OUT: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // The snapshot is taken from the register file at request time. A CPU
  // write made while that voice is being requested is only seen on the next sweep.
  assign snap_sel   = start_sweep ? 4'd0 : (idx + 4'd1);
  assign snap_word  = voice_mem[snap_sel];
  assign sample_ext = {{4{v_sample[BITDEPTH-1]}}, v_sample};

  // Scale the mix and saturate it to the DAC range.
  always_comb begin
    shifted = acc >>> MIXSHIFT;
    if (shifted > PCM_MAX)      pcm_next = PCM_MAX[BITDEPTH-1:0];
    else if (shifted < PCM_MIN) pcm_next = PCM_MIN[BITDEPTH-1:0];
    else                        pcm_next = shifted[BITDEPTH-1:0];
  end

  // Sweep datapath: voice snapshots, accumulator and PCM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      v_req     <= 1'b0;
      {v_cfg, v_tune, v_attack, v_decay, v_note, v_gate} <= '0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      if (start_sweep) begin
        acc   <= '0;
        idx   <= '0;
        v_req <= 1'b1;
        {v_cfg, v_tune, v_attack, v_decay, v_note, v_gate} <= snap_word;
      end
      if (take_sample) begin
        acc <= acc + sample_ext;
        if (idx != LAST_IDX) begin
          idx <= idx + 4'd1;
          {v_cfg, v_tune, v_attack, v_decay, v_note, v_gate} <= snap_word;
        end else begin
          v_req <= 1'b0;
        end
      end
      if (state == S_OUT) begin
        pcm       <= pcm_next;
        pcm_valid <= 1'b1;
      end
    end
  end

  assign v_idx     = idx;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_synth_multivoice.sv
// Bench for synth_multivoice. Instance a has 4 voices and a mix shift of 2.
// Instance b has 16 voices and no shift, so its output saturates.
module tb_synth_multivoice;

  localparam int BD = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT a signals ----------------
  logic [4:0]           a_addr;
  logic [31:0]          a_din;
  logic [31:0]          a_dout;
  logic                 a_wen;
  logic                 a_ren;
  logic                 a_ready;
  logic                 a_req;
  logic [3:0]           a_idx;
  logic                 a_cfg;
  logic [6:0]           a_tune;
  logic [7:0]           a_attack;
  logic [7:0]           a_decay;
  logic [6:0]           a_note;
  logic                 a_gate;
  logic                 a_ack;
  logic signed [BD-1:0] a_sample;
  logic signed [BD-1:0] a_pcm;
  logic                 a_pcm_valid;
  logic                 a_busy;
  logic [1:0]           a_state;

  // ---------------- DUT b signals ----------------
  logic [4:0]           b_addr = 5'd0;
  logic [31:0]          b_din = 32'd0;
  logic [31:0]          b_dout;
  logic                 b_wen = 1'b0;
  logic                 b_ren = 1'b0;
  logic                 b_ready;
  logic                 b_req;
  logic [3:0]           b_idx;
  logic                 b_cfg;
  logic [6:0]           b_tune;
  logic [7:0]           b_attack;
  logic [7:0]           b_decay;
  logic [6:0]           b_note;
  logic                 b_gate;
  logic                 b_ack;
  logic signed [BD-1:0] b_sample;
  logic signed [BD-1:0] b_pcm;
  logic                 b_pcm_valid;
  logic                 b_busy;
  logic [1:0]           b_state;

  synth_multivoice #(.NVOICES(4), .BITDEPTH(BD), .SAMPLECLOCK_DIV(8), .MIXSHIFT(2)) dut_a (
    .clk(clk), .rst(rst), .addr(a_addr), .data_in(a_din), .data_out(a_dout),
    .wen(a_wen), .ren(a_ren), .ready(a_ready), .v_req(a_req), .v_idx(a_idx),
    .v_cfg(a_cfg), .v_tune(a_tune), .v_attack(a_attack), .v_decay(a_decay),
    .v_note(a_note), .v_gate(a_gate), .v_ack(a_ack), .v_sample(a_sample),
    .pcm(a_pcm), .pcm_valid(a_pcm_valid), .busy(a_busy), .state_dbg(a_state)
  );

  synth_multivoice #(.NVOICES(16), .BITDEPTH(BD), .SAMPLECLOCK_DIV(8), .MIXSHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .addr(b_addr), .data_in(b_din), .data_out(b_dout),
    .wen(b_wen), .ren(b_ren), .ready(b_ready), .v_req(b_req), .v_idx(b_idx),
    .v_cfg(b_cfg), .v_tune(b_tune), .v_attack(b_attack), .v_decay(b_decay),
    .v_note(b_note), .v_gate(b_gate), .v_ack(b_ack), .v_sample(b_sample),
    .pcm(b_pcm), .pcm_valid(b_pcm_valid), .busy(b_busy), .state_dbg(b_state)
  );

  // ---------------- voice engine models ----------------
  // Each engine acks after dly cycles of a held request and returns a per-voice sample.
  logic signed [BD-1:0] samp_a [16];
  logic signed [BD-1:0] samp_b [16];
  int dly_a = 0;
  int dly_b = 0;
  int wait_a = 0;
  int wait_b = 0;

  always @(posedge clk) begin
    if (a_req && !a_ack) wait_a <= wait_a + 1;
    else                 wait_a <= 0;
  end
  always @(posedge clk) begin
    if (b_req && !b_ack) wait_b <= wait_b + 1;
    else                 wait_b <= 0;
  end

  assign a_ack    = a_req && (wait_a >= dly_a);
  assign b_ack    = b_req && (wait_b >= dly_b);
  assign a_sample = samp_a[a_idx];
  assign b_sample = samp_b[b_idx];

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model_mem [4];
  logic [31:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] d);
    if (d[31]) return d;
    return {1'b0, old[30:8], d[7:0]};
  endfunction

  // Mixed output: sum >>> shift (floor), then clamped to the signed BD-bit range.
  function automatic int mix_ref(input int sum, input int sh);
    int v;
    v = sum >>> sh;
    if (v > 8191)  v = 8191;
    if (v < -8192) v = -8192;
    return v;
  endfunction

  function automatic int sum_a();
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(samp_a[i]);
    return s;
  endfunction

  function automatic int sum_b();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(samp_b[i]);
    return s;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_access(input logic [4:0] a, input logic [31:0] d, input logic is_wr,
                            output logic [31:0] rd);
    @(negedge clk);
    a_addr = a;
    a_din  = d;
    a_wen  = is_wr;
    a_ren  = !is_wr;
    check("ready_not_same_cycle", a_ready, 0);
    @(negedge clk);
    check("ready_after_one_cycle", a_ready, 1);
    rd = a_dout;
    @(negedge clk);
    a_wen = 1'b0;
    a_ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    cpu_access(a, d, 1'b1, unused_rd);
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [31:0] rd);
    cpu_access(a, 32'd0, 1'b0, rd);
  endtask

  task automatic wait_pcm_a();
    logic ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (a_pcm_valid) begin ok = 1'b1; break; end
    end
    check("pcm_a_strobe_seen", ok, 1);
  endtask

  task automatic wait_pcm_b();
    logic ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (b_pcm_valid) begin ok = 1'b1; break; end
    end
    check("pcm_b_strobe_seen", ok, 1);
  endtask

  task automatic wait_req_idx_a(input logic [3:0] want);
    logic ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (a_req && a_idx == want) begin ok = 1'b1; break; end
    end
    check("req_idx_seen", ok, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  logic [31:0] rd;
  logic [31:0] new_word;
  logic [31:0] old_word;
  logic [4:0]  wa;
  int          t_prev;
  int          strobes;

  initial begin
    a_addr = 5'd0; a_din = 32'd0; a_wen = 1'b0; a_ren = 1'b0;
    for (int i = 0; i < 16; i++) begin
      samp_a[i] = '0;
      samp_b[i] = '0;
    end
    for (int i = 0; i < 4; i++) model_mem[i] = 32'd0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pcm", a_pcm, 0);
    check("rst_pcm_valid", a_pcm_valid, 0);
    check("rst_v_req", a_req, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ready", a_ready, 0);
    check("rst_v_word", {a_cfg, a_tune, a_attack, a_decay, a_note, a_gate}, 0);
    check("rst_v_idx", a_idx, 0);
    check("rst_state", a_state, 0);
    check("rst_pcm_b", b_pcm, 0);
    rst = 1'b0;

    cpu_read(5'd0, rd);
    check("rst_voice0", rd, 0);
    cpu_read(5'd16, rd);
    check("rst_status", rd, 0);

    // full write, then note/gate-only write
    cpu_write(5'd0, 32'h8AF04079);
    model_mem[0] = merge_word(model_mem[0], 32'h8AF04079);
    cpu_read(5'd0, rd);
    check("wr_full", rd, 32'h8AF04079);
    cpu_write(5'd0, 32'h00000078);
    model_mem[0] = merge_word(model_mem[0], 32'h00000078);
    cpu_read(5'd0, rd);
    check("wr_partial", rd, 32'h0AF04078);

    // out-of-range voice slots and the status alias at address 20
    cpu_write(5'd5, 32'hFFFFFFFF);
    cpu_read(5'd5, rd);
    check("oor_voice5", rd, 0);
    cpu_write(5'd20, 32'hFFFFFFFE);
    cpu_read(5'd20, rd);
    check("addr20_read", rd, 0);
    cpu_read(5'd0, rd);
    check("addr20_no_side_effect", rd, model_mem[0]);

    // random register traffic against the model
    for (int n = 0; n < 6; n++) begin
      wa = 5'($urandom_range(0, 7));
      new_word = $urandom;
      cpu_write(wa, new_word);
      if (wa < 5'd4) model_mem[wa[1:0]] = merge_word(model_mem[wa[1:0]], new_word);
    end
    for (int i = 0; i < 8; i++) begin
      cpu_read(5'(i), rd);
      check("rand_readback", rd, (i < 4) ? model_mem[i] : 32'd0);
    end

    // mixing of fixed samples and sample-period spacing
    wait_pcm_a();
    check("pcm_zero_mix", a_pcm, mix_ref(sum_a(), 2));
    samp_a[0] = 14'sd1000; samp_a[1] = 14'sd2000; samp_a[2] = -14'sd500; samp_a[3] = 14'sd300;
    wait_pcm_a();
    check("pcm_700", a_pcm, 700);
    check("pcm_700_model", a_pcm, mix_ref(sum_a(), 2));
    t_prev = cyc;
    repeat (10) @(negedge clk);
    check("pcm_hold", a_pcm, 700);
    check("pcm_valid_pulse", a_pcm_valid, 0);
    wait_pcm_a();
    check("pcm_period", cyc - t_prev, 256);
    check("pcm_700_again", a_pcm, 700);

    // random samples, instance a
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) samp_a[i] = 14'($urandom_range(0, 16383));
      exp_q.push_back(32'(mix_ref(sum_a(), 2)));
      wait_pcm_a();
      check("pcm_rand_a", a_pcm, exp_q.pop_front());
    end

    // saturation on instance b
    wait_pcm_b();
    for (int i = 0; i < 16; i++) samp_b[i] = 14'sd8191;
    wait_pcm_b();
    check("sat_pos", b_pcm, 8191);
    for (int i = 0; i < 16; i++) samp_b[i] = -14'sd8192;
    wait_pcm_b();
    check("sat_neg", b_pcm, -8192);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) samp_b[i] = 14'($urandom_range(0, 16383));
      exp_q.push_back(32'(mix_ref(sum_b(), 0)));
      wait_pcm_b();
      check("pcm_rand_b", b_pcm, exp_q.pop_front());
    end

    // snapshot isolation: rewrite voice 2 while it is being requested
    wait_pcm_a();
    dly_a = 40;
    wait_req_idx_a(4'd2);
    old_word = model_mem[2];
    check("snap_before", {a_cfg, a_tune, a_attack, a_decay, a_note, a_gate}, old_word);
    new_word = {1'b1, 31'($urandom)};
    cpu_write(5'd2, new_word);
    model_mem[2] = merge_word(model_mem[2], new_word);
    check("snap_still_req", {a_req, a_idx}, {1'b1, 4'd2});
    check("snap_unchanged", {a_cfg, a_tune, a_attack, a_decay, a_note, a_gate}, old_word);
    exp_q.push_back(32'(mix_ref(sum_a(), 2)));
    wait_pcm_a();
    check("pcm_slow_engine", a_pcm, exp_q.pop_front());
    dly_a = 0;
    wait_req_idx_a(4'd2);
    check("snap_next_sweep", {a_cfg, a_tune, a_attack, a_decay, a_note, a_gate}, model_mem[2]);

    // overrun: engine stalls past the next tick
    wait_pcm_a();
    dly_a = 300;
    wait_req_idx_a(4'd0);
    repeat (280) @(negedge clk);
    check("ovr_busy", a_busy, 1);
    cpu_read(5'd16, rd);
    check("ovr_status", rd, 3);
    dly_a = 0;
    exp_q.push_back(32'(mix_ref(sum_a(), 2)));
    wait_pcm_a();
    check("ovr_sweep_result", a_pcm, exp_q.pop_front());
    cpu_read(5'd16, rd);
    check("ovr_sticky", rd, 1);
    cpu_write(5'd16, 32'd1);
    cpu_read(5'd16, rd);
    check("ovr_cleared", rd, 0);

    // reset in the middle of a sweep
    wait_pcm_a();
    dly_a = 50;
    wait_req_idx_a(4'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dly_a = 0;
    check("rst_mid_v_req", a_req, 0);
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_pcm", a_pcm, 0);
    strobes = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_pcm_valid) strobes++;
    end
    check("rst_mid_no_strobe", strobes, 0);
    cpu_read(5'd2, rd);
    check("rst_mid_voice_clear", rd, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
